vga_scan_gen: RTL and testbench

Raster timing generator and pixel output stage for the 640x480@60 Hz VGA display. It produces the `DrawX`/`DrawY` scan coordinates consumed by `color_mapper` and the sprite logic. It registers the returned `VGA_R`/`VGA_G`/`VGA_B` together with sync and blank, so all pin signals stay pixel-aligned. It also emits a once-per-frame strobe that player and missile position logic uses to advance state.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_axis_counter.sv | 30 +++
 rtl/vga_scan_gen.sv | 136 +++++++++++++
 tb/tb_vga_scan_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the pin bundle type used by
// the scan generator and its axis counters.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;

    typedef struct packed {
        logic               hs_n;
        logic               vs_n;
        logic               blank_n;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } vga_pins_t;

    // Idle pin state: syncs deasserted (high), blanked, black.
    localparam vga_pins_t PINS_RESET = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0,
                                         r: '0, g: '0, b: '0};

    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N up counter used for both scan axes; wrap flags the terminal count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int MODULUS = H_TOTAL,
    parameter int WIDTH   = COORD_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= wrap ? '0 : r_count + WIDTH'(1);
        end
    end

    assign wrap  = (r_count == LAST);
    assign count = r_count;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: pixel-rate toggle, H/V scan counters, sync/blank
// decode and a registered pin stage so sync, blank and colour stay aligned.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COLOR_W-1:0] RGB_R,
    input  logic [COLOR_W-1:0] RGB_G,
    input  logic [COLOR_W-1:0] RGB_B,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               pix_en,
    output logic               frame_start,
    output logic               vblank,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int LP_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int LP_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] LP_H_VIS      = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] LP_H_SYNC_BEG = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] LP_H_SYNC_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] LP_V_VIS      = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] LP_V_SYNC_BEG = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] LP_V_SYNC_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               r_toggle;
    logic               r_frame_start;
    vga_pins_t          r_pins;

    logic               w_pix_en;
    logic               w_v_en;
    logic [COORD_W-1:0] w_hc;
    logic [COORD_W-1:0] w_vc;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_vis;
    vga_pins_t          w_next_pins;

    // The toggle itself is the pixel enable and the DAC clock.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_toggle <= 1'b0;
        end else begin
            r_toggle <= ~r_toggle;
        end
    end

    assign w_pix_en = r_toggle;
    assign w_v_en   = w_pix_en & w_h_wrap;

    vga_axis_counter #(
        .MODULUS(LP_H_TOTAL),
        .WIDTH  (COORD_W)
    ) u_hcount (
        .i_clk  (Clk),
        .i_reset(Reset),
        .i_en   (w_pix_en),
        .count  (w_hc),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .MODULUS(LP_V_TOTAL),
        .WIDTH  (COORD_W)
    ) u_vcount (
        .i_clk  (Clk),
        .i_reset(Reset),
        .i_en   (w_v_en),
        .count  (w_vc),
        .wrap   (w_v_wrap)
    );

    always_comb begin
        w_hs_raw    = ~in_window(w_hc, LP_H_SYNC_BEG, LP_H_SYNC_END);
        w_vs_raw    = ~in_window(w_vc, LP_V_SYNC_BEG, LP_V_SYNC_END);
        w_vis       = (w_hc < LP_H_VIS) && (w_vc < LP_V_VIS);
        w_next_pins = PINS_RESET;
        w_next_pins.hs_n    = w_hs_raw;
        w_next_pins.vs_n    = w_vs_raw;
        w_next_pins.blank_n = w_vis;
        if (w_vis) begin
            w_next_pins.r = RGB_R;
            w_next_pins.g = RGB_G;
            w_next_pins.b = RGB_B;
        end
    end

    // Pins capture the pixel being left on the same edge the counters advance.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pins        <= PINS_RESET;
            r_frame_start <= 1'b0;
        end else begin
            if (w_pix_en) begin
                r_pins <= w_next_pins;
            end
            r_frame_start <= w_pix_en & w_h_wrap & w_v_wrap;
        end
    end

    assign DrawX       = w_hc;
    assign DrawY       = w_vc;
    assign pix_en      = w_pix_en;
    assign VGA_CLK     = r_toggle;
    assign frame_start = r_frame_start;
    assign vblank      = (w_vc >= LP_V_VIS);
    assign VGA_HS      = r_pins.hs_n;
    assign VGA_VS      = r_pins.vs_n;
    assign VGA_BLANK_N = r_pins.blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_pins.r;
    assign VGA_G       = r_pins.g;
    assign VGA_B       = r_pins.b;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a shrunk-timing instance for whole-frame behaviour
// and a default-timing instance for line-level timing, both against a model.
module tb_vga_scan_gen;

    localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
    localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
    localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        pixEn;
        logic        fs;
        logic        vblank;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        blankN;
        logic        syncN;
        logic [23:0] rgb;
    } obs_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetS = 1'b1;
    logic       resetD = 1'b1;
    logic [7:0] rS, gS, bS, rD, gD, bD;
    logic [9:0] drawXS, drawYS, drawXD, drawYD;
    logic       pixEnS, fsS, vblankS, vclkS, hsS, vsS, blankNS, syncNS;
    logic       pixEnD, fsD, vblankD, vclkD, hsD, vsD, blankND, syncND;
    logic [7:0] vgaRS, vgaGS, vgaBS, vgaRD, vgaGD, vgaBD;

    int          checks = 0;
    int          passes = 0;
    int          kS = 0;
    int          kD = 0;
    logic [23:0] lastS = '0;
    logic [23:0] lastD = '0;
    logic        liveS = 1'b0;
    logic        liveD = 1'b0;
    logic        randomMode = 1'b0;
    logic        doneD = 1'b0;

    vga_scan_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dutS (
        .Clk(clock), .Reset(resetS),
        .RGB_R(rS), .RGB_G(gS), .RGB_B(bS),
        .DrawX(drawXS), .DrawY(drawYS),
        .pix_en(pixEnS), .frame_start(fsS), .vblank(vblankS),
        .VGA_CLK(vclkS), .VGA_HS(hsS), .VGA_VS(vsS),
        .VGA_BLANK_N(blankNS), .VGA_SYNC_N(syncNS),
        .VGA_R(vgaRS), .VGA_G(vgaGS), .VGA_B(vgaBS)
    );

    vga_scan_gen dutD (
        .Clk(clock), .Reset(resetD),
        .RGB_R(rD), .RGB_G(gD), .RGB_B(bD),
        .DrawX(drawXD), .DrawY(drawYD),
        .pix_en(pixEnD), .frame_start(fsD), .vblank(vblankD),
        .VGA_CLK(vclkD), .VGA_HS(hsD), .VGA_VS(vsD),
        .VGA_BLANK_N(blankND), .VGA_SYNC_N(syncND),
        .VGA_R(vgaRD), .VGA_G(vgaGD), .VGA_B(vgaBD)
    );

    // Expected outputs after k non-reset clock edges since the last reset edge.
    function automatic obs_t model(input int k, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input logic [23:0] last);
        obs_t m;
        int ht, vt, ft, p, idx, prv, px, py;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        ft  = ht * vt;
        p   = k / 2;
        idx = p % ft;
        m.x      = 10'(idx % ht);
        m.y      = 10'(idx / ht);
        m.pixEn  = (k % 2) == 1;
        m.vclk   = m.pixEn;
        m.vblank = (idx / ht) >= vv;
        m.fs     = (k >= 2) && ((k % 2) == 0) && (idx == 0);
        m.syncN  = 1'b0;
        if (p == 0) begin
            m.hs = 1'b1; m.vs = 1'b1; m.blankN = 1'b0; m.rgb = '0;
        end else begin
            prv = (p - 1) % ft;
            px  = prv % ht;
            py  = prv / ht;
            m.hs     = !(px >= hv + hf && px < hv + hf + hsw);
            m.vs     = !(py >= vv + vf && py < vv + vf + vsw);
            m.blankN = (px < hv) && (py < vv);
            m.rgb    = m.blankN ? last : 24'd0;
        end
        return m;
    endfunction

    function automatic obs_t sampleS();
        return '{x: drawXS, y: drawYS, pixEn: pixEnS, fs: fsS, vblank: vblankS, vclk: vclkS,
                 hs: hsS, vs: vsS, blankN: blankNS, syncN: syncNS, rgb: {vgaRS, vgaGS, vgaBS}};
    endfunction

    function automatic obs_t sampleD();
        return '{x: drawXD, y: drawYD, pixEn: pixEnD, fs: fsD, vblank: vblankD, vclk: vclkD,
                 hs: hsD, vs: vsD, blankN: blankND, syncN: syncND, rgb: {vgaRD, vgaGD, vgaBD}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic applyStimulus(input logic rst, input int cycles);
        resetS = rst;
        repeat (cycles) @(negedge clock);
    endtask

    // Edge bookkeeping for the model: edges since reset and colour at each pixel edge.
    always @(posedge clock) begin
        if (resetS) begin
            kS    <= 0;
            liveS <= 1'b1;
        end else begin
            if ((kS % 2) == 1) lastS <= {rS, gS, bS};
            kS <= kS + 1;
        end
        if (resetD) begin
            kD    <= 0;
            liveD <= 1'b1;
        end else begin
            if ((kD % 2) == 1) lastD <= {rD, gD, bD};
            kD <= kD + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (liveS) checkOutput("scanSmall", 64'(sampleS()),
                               64'(model(kS, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, lastS)));
        if (liveD) checkOutput("scanDefault", 64'(sampleD()),
                               64'(model(kD, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, lastD)));
    end

    // Colour drivers: coordinate pattern, or random once randomMode is set.
    initial begin
        obs_t mS, mD;
        {rS, gS, bS} = '0;
        {rD, gD, bD} = '0;
        forever begin
            @(negedge clock);
            mS = model(kS, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, lastS);
            mD = model(kD, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, lastD);
            if (randomMode) {rS, gS, bS} = 24'($urandom);
            else            {rS, gS, bS} = {mS.x[7:0], mS.y[7:0], 8'hA5};
            {rD, gD, bD} = {mD.x[7:0], mD.y[7:0], 8'hA5};
        end
    end

    // Default-timing instance: reset release and one full line of timing.
    initial begin
        int hsLow, blankHigh, firstX656, firstHsLow;
        logic seen101, seen701;
        hsLow = 0; blankHigh = 0; firstX656 = -1; firstHsLow = -1;
        seen101 = 1'b0; seen701 = 1'b0;
        resetD = 1'b1;
        repeat (3) @(negedge clock);
        resetD = 1'b0;
        checkOutput("dResetX", drawXD, 0);
        checkOutput("dResetY", drawYD, 0);
        checkOutput("dResetHs", hsD, 1);
        checkOutput("dResetVs", vsD, 1);
        checkOutput("dResetBlank", blankND, 0);
        checkOutput("dPixEnFirst", pixEnD, 0);
        @(negedge clock);
        checkOutput("dPixEnSecond", pixEnD, 1);
        for (int i = 0; i < 1700; i++) begin
            @(negedge clock);
            if (kD >= 2 && kD <= 1601) begin
                if (!hsD) hsLow++;
                if (blankND) blankHigh++;
            end
            if (firstX656 < 0 && drawXD == 10'd656) firstX656 = kD;
            if (firstHsLow < 0 && !hsD) firstHsLow = kD;
            if (!seen101 && drawXD == 10'd101) begin
                seen101 = 1'b1;
                checkOutput("dColorAlign", {vgaRD, vgaGD, vgaBD}, {8'd100, 8'd0, 8'hA5});
            end
            if (!seen701 && drawXD == 10'd701) begin
                seen701 = 1'b1;
                checkOutput("dBlankAt700", blankND, 0);
                checkOutput("dBlackAt700", {vgaRD, vgaGD, vgaBD}, 0);
            end
        end
        checkOutput("dHsLowClk", 64'(hsLow), 64'(192));
        checkOutput("dBlankHighClk", 64'(blankHigh), 64'(1280));
        checkOutput("dHsFallDelay", 64'(firstHsLow - firstX656), 64'(2));
        doneD = 1'b1;
    end

    // Shrunk-timing instance: frames, frame_start spacing, mid-frame reset.
    initial begin
        int firstFs, vsLow, c;
        logic fsPrev, periodChecked, seenY9, seenY10, found;
        firstFs = -1; vsLow = 0; fsPrev = 1'b0; periodChecked = 1'b0;
        seenY9 = 1'b0; seenY10 = 1'b0; found = 1'b0;
        $display("[TB] starting vga_scan_gen bench");
        applyStimulus(1'b1, 3);
        resetS = 1'b0;
        checkOutput("sResetX", drawXS, 0);
        checkOutput("sResetY", drawYS, 0);
        checkOutput("sResetHs", hsS, 1);
        checkOutput("sResetVs", vsS, 1);
        checkOutput("sResetBlank", blankNS, 0);
        checkOutput("sPixEnFirst", pixEnS, 0);
        @(negedge clock);
        checkOutput("sPixEnSecond", pixEnS, 1);
        for (int i = 0; i < 2200; i++) begin
            @(negedge clock);
            if (i == 1100) randomMode = 1'b1;
            if (fsPrev) checkOutput("sFsWidth", fsS, 0);
            if (fsS) begin
                if (firstFs < 0) firstFs = i;
                else if (!periodChecked) begin
                    periodChecked = 1'b1;
                    checkOutput("sFsPeriod", 64'(i - firstFs), 64'(1020));
                    checkOutput("sVsLowClk", 64'(vsLow), 64'(120));
                end
            end
            if (firstFs >= 0 && !periodChecked && !vsS) vsLow++;
            if (!seenY9 && drawYS == 10'd9) begin
                seenY9 = 1'b1;
                checkOutput("sVblankBefore", vblankS, 0);
            end
            if (!seenY10 && drawYS == 10'd10) begin
                seenY10 = 1'b1;
                checkOutput("sVblankRise", vblankS, 1);
            end
            fsPrev = fsS;
        end
        checkOutput("sFsSeen", periodChecked, 1);

        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clock);
            if (drawXS == 10'd8 && drawYS == 10'd5) found = 1'b1;
        end
        checkOutput("sMidReach", found, 1);
        if (found) begin
            applyStimulus(1'b1, 1);
            resetS = 1'b0;
            checkOutput("sMidX", drawXS, 0);
            checkOutput("sMidY", drawYS, 0);
            checkOutput("sMidNoFs", fsS, 0);
            c = 0;
            while (c < 1100) begin
                @(negedge clock);
                c++;
                if (fsS) break;
            end
            checkOutput("sFsAfterReset", 64'(c), 64'(1020));
        end

        for (int i = 0; i < 5000 && !doneD; i++) @(negedge clock);
        checkOutput("dFinished", doneD, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
